conv_window_sched: RTL and testbench

Frame-level controller for the streaming convolution datapath. It admits one image frame per start command and tracks the column/row position of every accepted pixel. It drives line-buffer write/read enables and flags each position where a full KxK window exists, so the MAC array fires exactly (W-K+1)*(H-K+1) times per frame. It sits between the pixel source, the line buffers and the convolution core, and adds backpressure and completion handshakes.

---
 rtl/conv_pkg.sv | 13 +
 rtl/pixel_pos_counter.sv | 30 +++
 rtl/conv_window_sched.sv | 84 ++++++++
 tb/tb_conv_window_sched.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared state type and sizing helpers for the convolution window scheduler
package conv_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;
  localparam int KERNEL_DEF = 3;
  localparam int IMG_WIDTH_DEF = 220;
  localparam int IMG_HEIGHT_DEF = 220;
  localparam int COL_W = $clog2(IMG_WIDTH_DEF);
  localparam int ROW_W = $clog2(IMG_HEIGHT_DEF);
  localparam int WIN_PER_FRAME = (IMG_WIDTH_DEF - KERNEL_DEF + 1) * (IMG_HEIGHT_DEF - KERNEL_DEF + 1);
  function automatic int win_per_frame(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction
endpackage

// File: rtl/pixel_pos_counter.sv
// pixel_pos_counter: raster column/row position of the next pixel to be accepted
module pixel_pos_counter #(
  parameter int IMG_WIDTH = 220,
  parameter int IMG_HEIGHT = 220
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          inc,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic [$clog2(IMG_HEIGHT)-1:0] row,
  output logic                          last_col,
  output logic                          last_pix
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  assign last_col = col == CW'(IMG_WIDTH - 1);
  assign last_pix = last_col && row == RW'(IMG_HEIGHT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      col <= last_col ? '0 : col + CW'(1);
      row <= last_pix ? '0 : last_col ? row + RW'(1) : row;
    end
endmodule

// File: rtl/conv_window_sched.sv
// conv_window_sched: frame controller issuing line-buffer strobes and KxK window-valid flags
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int KERNEL = KERNEL_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic                          out_ready,
  output logic                          lb_wr_en,
  output logic                          lb_rd_en,
  output logic                          win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic [$clog2(IMG_HEIGHT)-1:0] row,
  output logic                          busy,
  output logic                          frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  state_t state;
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic last_col, last_pix, accept, clr;
  assign pix_ready = state == PRIME || (state == RUN && out_ready);
  assign accept = pix_valid && pix_ready;
  assign clr = state == IDLE ? start : abort;
  pixel_pos_counter #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) u_pos (
    .clk(clk), .rst(rst), .clr(clr), .inc(accept),
    .col(pos_col), .row(pos_row), .last_col(last_col), .last_pix(last_pix)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      lb_wr_en <= 1'b0;
      lb_rd_en <= 1'b0;
      win_valid <= 1'b0;
      col <= '0;
      row <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      lb_wr_en <= accept;
      lb_rd_en <= accept && pos_row != '0;
      win_valid <= accept && pos_row >= RW'(KERNEL - 1) && pos_col >= CW'(KERNEL - 1);
      frame_done <= 1'b0;
      if (accept) begin
        col <= pos_col;
        row <= pos_row;
      end
      case (state)
        IDLE:
          if (start) begin
            state <= PRIME;
            busy <= 1'b1;
            col <= '0;
            row <= '0;
          end
        PRIME:
          if (abort) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (accept && last_col && pos_row == RW'(KERNEL - 2))
            state <= RUN;
        RUN:
          if (abort) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (accept && last_pix) begin
            state <= DONE;
            frame_done <= 1'b1;
          end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: scoreboard bench for a 5x4 frame with a 3x3 kernel
module tb_conv_window_sched;
  localparam int W = 5;
  localparam int H = 4;
  localparam int K = 3;
  localparam int PRIME_N = (K - 1) * W;
  typedef struct {
    logic rd;
    logic win;
    logic done;
    int   c;
    int   r;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic pix_valid = 1'b0;
  logic out_ready = 1'b1;
  logic pix_ready, lb_wr_en, lb_rd_en, win_valid, busy, frame_done;
  logic [$clog2(W)-1:0] col;
  logic [$clog2(H)-1:0] row;
  exp_t q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;
  int wins = 0;
  int dones = 0;
  int n = 0;
  bit frame_on = 0;
  bit dn = 0;
  conv_window_sched #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .out_ready(out_ready),
    .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .win_valid(win_valid),
    .col(col), .row(row), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction
  always @(negedge clk)
    if (rst) begin
      if (lb_wr_en) begin
        if (q.size() == 0) chk("unexpected lb_wr_en", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("lb_rd_en", lb_rd_en, mon_e.rd);
          chk("win_valid", win_valid, mon_e.win);
          chk("frame_done", frame_done, mon_e.done);
          chk("col", col, mon_e.c);
          chk("row", row, mon_e.r);
        end
      end else
        chk("idle strobes", {lb_rd_en, win_valid, frame_done}, 0);
      if (win_valid) wins++;
      if (frame_done) dones++;
    end
  task automatic beat(input logic v, input logic o, input logic s, input logic a);
    logic er;
    bit st;
    exp_t e;
    @(negedge clk);
    pix_valid = v;
    out_ready = o;
    start = s;
    abort = a;
    #1;
    er = frame_on && (n < PRIME_N || o);
    chk("pix_ready", pix_ready, er);
    chk("busy", busy, frame_on || dn);
    st = s && !frame_on && !dn;
    dn = 0;
    if (v && er) begin
      e.r = n / W;
      e.c = n % W;
      e.rd = e.r >= 1;
      e.win = e.r >= K - 1 && e.c >= K - 1;
      e.done = n == W * H - 1;
      q.push_back(e);
      n++;
      if (n == W * H) begin
        frame_on = 0;
        dn = 1;
      end
    end
    if (a && frame_on) begin
      frame_on = 0;
      n = 0;
    end
    if (st) begin
      frame_on = 1;
      n = 0;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    pix_valid = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("reset outputs", {lb_wr_en, lb_rd_en, win_valid, busy, frame_done, pix_ready}, 0);
    chk("reset col", col, 0);
    chk("reset row", row, 0);
    chk("reset pending", q.size(), 0);
    frame_on = 0;
    n = 0;
    dn = 0;
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask
  task automatic run_frame(input int mode, input int start_at, input int abort_at,
                           input int rst_at, input int exp_win, input int exp_done);
    int w0 = wins;
    int d0 = dones;
    int cyc = 0;
    logic v, o;
    beat(1'b0, 1'b1, 1'b1, mode == 3);
    while (frame_on && cyc < 2000) begin
      cyc++;
      v = mode == 2 ? logic'($urandom_range(0, 1)) : 1'b1;
      o = mode == 1 ? logic'(cyc[0]) : 1'b1;
      if (n == rst_at) begin
        do_reset();
        break;
      end
      beat(v, o, n == start_at, n == abort_at);
    end
    chk("frame completes", frame_on, 0);
    repeat (3) beat(1'b0, 1'b1, 1'b0, 1'b0);
    chk("windows", wins - w0, exp_win);
    chk("frame_done count", dones - d0, exp_done);
  endtask
  initial begin
    #1;
    chk("async reset outputs", {lb_wr_en, lb_rd_en, win_valid, busy, frame_done, pix_ready}, 0);
    chk("async reset pos", {col, row}, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (2) beat(1'b1, 1'b1, 1'b0, 1'b1);
    run_frame(0, -1, -1, -1, 6, 1);
    run_frame(1, -1, -1, -1, 6, 1);
    run_frame(0, 7, -1, -1, 6, 1);
    run_frame(0, -1, -1, 12, 0, 0);
    run_frame(0, -1, -1, -1, 6, 1);
    run_frame(0, -1, 9, -1, 0, 0);
    run_frame(0, -1, -1, -1, 6, 1);
    run_frame(3, -1, -1, -1, 6, 1);
    run_frame(2, -1, -1, -1, 6, 1);
    chk("leftover expectations", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
